// File: rtl/jtdd2_romarb.sv
// Four-slot ROM read arbiter with a one-entry cache per slot, feeding a single SDRAM read port.
// Pending slots are served round-robin; the cache is invalidated whenever a download is in progress.
module jtdd2_romarb #(
  parameter logic [21:0] SLOT0_OFFSET = 22'h0,
  parameter logic [21:0] SLOT1_OFFSET = 22'h0,
  parameter logic [21:0] SLOT2_OFFSET = 22'h0,
  parameter logic [21:0] SLOT3_OFFSET = 22'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        downloading,
  input  logic        slot0_cs,
  input  logic        slot1_cs,
  input  logic        slot2_cs,
  input  logic        slot3_cs,
  input  logic [19:0] slot0_addr,
  input  logic [19:0] slot1_addr,
  input  logic [19:0] slot2_addr,
  input  logic [19:0] slot3_addr,
  output logic [15:0] slot0_dout,
  output logic [15:0] slot1_dout,
  output logic [15:0] slot2_dout,
  output logic [15:0] slot3_dout,
  output logic        slot0_ok,
  output logic        slot1_ok,
  output logic        slot2_ok,
  output logic        slot3_ok,
  output logic        sdram_req,
  output logic [21:0] sdram_addr,
  input  logic        sdram_ack,
  input  logic        data_rdy,
  input  logic [31:0] data_read,
  output logic        refresh_en
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t      state, state_d;
  logic [3:0]  cs_v;
  logic [19:0] addr_v [4];
  logic [3:0]  valid;
  logic [19:0] tag [4];
  logic [15:0] data [4];
  logic [3:0]  ok_v;
  logic [3:0]  pending;
  logic [1:0]  last_grant;
  logic [1:0]  gnt_slot;
  logic [19:0] gnt_addr;
  logic        found;
  logic [1:0]  sel;
  logic [1:0]  idx;
  logic        grant_en;
  logic [21:0] sel_offset;
  logic        unused_hi;

  assign cs_v      = {slot3_cs, slot2_cs, slot1_cs, slot0_cs};
  assign addr_v[0] = slot0_addr;
  assign addr_v[1] = slot1_addr;
  assign addr_v[2] = slot2_addr;
  assign addr_v[3] = slot3_addr;
  assign unused_hi = ^data_read[31:16];

  always_comb begin
    ok_v = '0;
    for (int i = 0; i < 4; i++)
      ok_v[i] = cs_v[i] & valid[i] & (tag[i] == addr_v[i]);
  end

  assign pending = cs_v & ~ok_v;

  assign slot0_ok   = ok_v[0];
  assign slot1_ok   = ok_v[1];
  assign slot2_ok   = ok_v[2];
  assign slot3_ok   = ok_v[3];
  assign slot0_dout = data[0];
  assign slot1_dout = data[1];
  assign slot2_dout = data[2];
  assign slot3_dout = data[3];

  // Search starts one past the last grant so every pending slot is served within four accesses.
  always_comb begin
    found = 1'b0;
    sel   = last_grant;
    idx   = last_grant;
    for (int i = 1; i <= 4; i++) begin
      idx = last_grant + 2'(i);
      if (!found && pending[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
  end

  always_comb begin
    sel_offset = SLOT0_OFFSET;
    case (sel)
      2'd0: sel_offset = SLOT0_OFFSET;
      2'd1: sel_offset = SLOT1_OFFSET;
      2'd2: sel_offset = SLOT2_OFFSET;
      2'd3: sel_offset = SLOT3_OFFSET;
      default: sel_offset = SLOT0_OFFSET;
    endcase
  end

  always_comb begin
    state_d    = state;
    grant_en   = 1'b0;
    sdram_req  = (state == REQ);
    refresh_en = (state == IDLE) && (pending == 4'd0) && !downloading && !rst;
    case (state)
      IDLE: if (found && !downloading) begin
        grant_en = 1'b1;
        state_d  = REQ;
      end
      REQ:  if (sdram_ack) state_d = WAIT;
      WAIT: if (data_rdy)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (downloading) state_d = IDLE;
  end

  // A download abandons any access in flight and drops every cached entry; tags and data are kept.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      sdram_addr <= '0;
      valid      <= '0;
      last_grant <= 2'd3;
      gnt_slot   <= 2'd0;
      gnt_addr   <= '0;
      for (int i = 0; i < 4; i++) begin
        tag[i]  <= '0;
        data[i] <= '0;
      end
    end else begin
      state <= state_d;
      if (downloading) begin
        valid <= '0;
      end else begin
        if (grant_en) begin
          gnt_slot   <= sel;
          gnt_addr   <= addr_v[sel];
          sdram_addr <= sel_offset + {2'b00, addr_v[sel]};
          last_grant <= sel;
        end
        if (state == WAIT && data_rdy) begin
          data[gnt_slot]  <= data_read[15:0];
          tag[gnt_slot]   <= gnt_addr;
          valid[gnt_slot] <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_jtdd2_romarb.sv
// Bench for jtdd2_romarb: directed scenarios followed by random traffic, all checked
// against a transaction-level cache/arbiter model held in the bench.
module tb_jtdd2_romarb;

  localparam logic [21:0] OFF0 = 22'h00_0000;
  localparam logic [21:0] OFF1 = 22'h06_0000;
  localparam logic [21:0] OFF2 = 22'h3F_FFF0;
  localparam logic [21:0] OFF3 = 22'h10_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        downloading = 1'b0;
  logic [3:0]  cs = 4'd0;
  logic [19:0] addr [4];
  logic [15:0] dout [4];
  logic [3:0]  ok;
  logic        sdram_req;
  logic [21:0] sdram_addr;
  logic        sdram_ack = 1'b0;
  logic        data_rdy = 1'b0;
  logic [31:0] data_read = 32'd0;
  logic        refresh_en;

  int checks = 0;
  int errors = 0;
  bit auto_ctrl = 1'b0;
  bit prev_req = 1'b0;
  logic [21:0] obs_q [$];

  int          m_phase;
  int          m_last;
  int          m_gslot;
  logic [19:0] m_gaddr;
  bit          m_valid [4];
  logic [19:0] m_tag [4];
  logic [15:0] m_data [4];
  logic [21:0] m_sdaddr;

  always #5 clk = ~clk;

  jtdd2_romarb #(
    .SLOT0_OFFSET(OFF0), .SLOT1_OFFSET(OFF1), .SLOT2_OFFSET(OFF2), .SLOT3_OFFSET(OFF3)
  ) dut (
    .clk(clk), .rst(rst), .downloading(downloading),
    .slot0_cs(cs[0]), .slot1_cs(cs[1]), .slot2_cs(cs[2]), .slot3_cs(cs[3]),
    .slot0_addr(addr[0]), .slot1_addr(addr[1]), .slot2_addr(addr[2]), .slot3_addr(addr[3]),
    .slot0_dout(dout[0]), .slot1_dout(dout[1]), .slot2_dout(dout[2]), .slot3_dout(dout[3]),
    .slot0_ok(ok[0]), .slot1_ok(ok[1]), .slot2_ok(ok[2]), .slot3_ok(ok[3]),
    .sdram_req(sdram_req), .sdram_addr(sdram_addr), .sdram_ack(sdram_ack),
    .data_rdy(data_rdy), .data_read(data_read), .refresh_en(refresh_en)
  );

  function automatic logic [21:0] offs(input int s);
    case (s)
      0: return OFF0;
      1: return OFF1;
      2: return OFF2;
      default: return OFF3;
    endcase
  endfunction

  function automatic bit m_ok(input int i);
    return cs[i] && m_valid[i] && (m_tag[i] == addr[i]);
  endfunction

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  // Advance the reference by one clock edge using the inputs that were stable across it.
  task automatic modelUpdate();
    bit got;
    int s;
    if (rst) begin
      m_phase = 0; m_last = 3; m_sdaddr = '0; m_gslot = 0; m_gaddr = '0;
      for (int i = 0; i < 4; i++) begin
        m_valid[i] = 1'b0; m_tag[i] = '0; m_data[i] = '0;
      end
    end else if (downloading) begin
      m_phase = 0;
      for (int i = 0; i < 4; i++) m_valid[i] = 1'b0;
    end else begin
      case (m_phase)
        0: begin
          got = 1'b0;
          for (int k = 1; k <= 4; k++) begin
            s = (m_last + k) % 4;
            if (!got && cs[s] && !m_ok(s)) begin
              got = 1'b1;
              m_gslot = s;
              m_gaddr = addr[s];
              m_sdaddr = offs(s) + {2'b00, addr[s]};
              m_last = s;
              m_phase = 1;
            end
          end
        end
        1: if (sdram_ack) m_phase = 2;
        default: if (data_rdy) begin
          m_data[m_gslot]  = data_read[15:0];
          m_tag[m_gslot]   = m_gaddr;
          m_valid[m_gslot] = 1'b1;
          m_phase = 0;
        end
      endcase
    end
  endtask

  task automatic checkOutput();
    bit any_pend;
    any_pend = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("ok%0d", i), ok[i], m_ok(i));
      chk($sformatf("dout%0d", i), dout[i], m_data[i]);
      if (cs[i] && !m_ok(i)) any_pend = 1'b1;
    end
    chk("sdram_req", sdram_req, m_phase == 1);
    chk("sdram_addr", sdram_addr, m_sdaddr);
    chk("refresh_en", refresh_en, !rst && !downloading && m_phase == 0 && !any_pend);
  endtask

  task automatic applyStimulus();
    @(posedge clk);
    modelUpdate();
    @(negedge clk);
    checkOutput();
    if (sdram_req && !prev_req) obs_q.push_back(sdram_addr);
    prev_req = sdram_req;
    if (auto_ctrl) begin
      data_rdy  = sdram_ack;
      sdram_ack = sdram_req;
      data_read = $urandom;
    end
  endtask

  task automatic doReset();
    rst = 1'b1; cs = 4'd0; sdram_ack = 1'b0; data_rdy = 1'b0; downloading = 1'b0;
    applyStimulus();
    applyStimulus();
    rst = 1'b0;
    applyStimulus();
  endtask

  task automatic waitReq(input string name);
    for (int n = 0; n < 16 && !sdram_req; n++) applyStimulus();
    chk(name, sdram_req, 1'b1);
  endtask

  task automatic runCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus();
  endtask

  initial begin
    for (int i = 0; i < 4; i++) addr[i] = 20'd0;

    // Idle with no requests; stray handshakes must not disturb anything.
    doReset();
    chk("idle_refresh", refresh_en, 1'b1);
    chk("idle_req", sdram_req, 1'b0);
    sdram_ack = 1'b1; data_rdy = 1'b1; data_read = 32'hDEAD_BEEF;
    applyStimulus();
    sdram_ack = 1'b0; data_rdy = 1'b0;
    applyStimulus();
    chk("stray_refresh", refresh_en, 1'b1);
    chk("stray_dout0", dout[0], 16'h0000);

    // Slot 1 through its offset, ack one cycle after req, data two cycles after ack.
    addr[1] = 20'h00010; cs = 4'b0010;
    waitReq("s1_req");
    chk("s1_addr", sdram_addr, 22'h06_0010);
    applyStimulus();
    sdram_ack = 1'b1; applyStimulus();
    sdram_ack = 1'b0; applyStimulus();
    data_rdy = 1'b1; data_read = 32'hABCD_1234; applyStimulus();
    data_rdy = 1'b0;
    chk("s1_dout", dout[1], 16'h1234);
    chk("s1_ok", ok[1], 1'b1);

    // All four slots at once: grants must come out 0,1,2,3 (slot 2 wraps past 2^22).
    doReset();
    auto_ctrl = 1'b1;
    obs_q.delete();
    addr[0] = 20'h00100; addr[1] = 20'h00200; addr[2] = 20'h00300; addr[3] = 20'h00400;
    cs = 4'b1111;
    runCycles(16);
    chk("rr_count", obs_q.size(), 4);
    if (obs_q.size() == 4) begin
      chk("rr_g0", obs_q[0], 22'h00_0100);
      chk("rr_g1", obs_q[1], 22'h06_0200);
      chk("rr_g2", obs_q[2], 22'h00_02F0);
      chk("rr_g3", obs_q[3], 22'h10_0400);
    end
    chk("rr_allok", ok, 4'b1111);
    addr[1] = 20'h00201;
    runCycles(6);
    obs_q.delete();
    addr[0] = 20'h00101; addr[2] = 20'h00301;
    runCycles(10);
    chk("rr2_count", obs_q.size(), 2);
    if (obs_q.size() == 2) begin
      chk("rr2_first", obs_q[0], 22'h00_02F1);
      chk("rr2_second", obs_q[1], 22'h00_0101);
    end
    auto_ctrl = 1'b0; sdram_ack = 1'b0; data_rdy = 1'b0;

    // Address moves from 5 to 6 while the access is outstanding.
    doReset();
    addr[0] = 20'd5; cs = 4'b0001;
    waitReq("mv_req5");
    chk("mv_addr5", sdram_addr, 22'd5);
    sdram_ack = 1'b1; applyStimulus();
    sdram_ack = 1'b0; addr[0] = 20'd6; applyStimulus();
    data_rdy = 1'b1; data_read = 32'h0000_BEEF; applyStimulus();
    data_rdy = 1'b0;
    chk("mv_ok0", ok[0], 1'b0);
    chk("mv_dout0", dout[0], 16'hBEEF);
    waitReq("mv_req6");
    chk("mv_addr6", sdram_addr, 22'd6);
    addr[0] = 20'd5; applyStimulus();
    chk("mv_tag5", ok[0], 1'b1);

    // Download pulse while waiting for data: the late data must not fill.
    doReset();
    addr[0] = 20'h00077; cs = 4'b0001;
    waitReq("dl_req");
    sdram_ack = 1'b1; applyStimulus();
    sdram_ack = 1'b0; downloading = 1'b1; applyStimulus();
    chk("dl_req_low", sdram_req, 1'b0);
    chk("dl_refresh", refresh_en, 1'b0);
    downloading = 1'b0; data_rdy = 1'b1; data_read = 32'h0000_5555; applyStimulus();
    data_rdy = 1'b0;
    chk("dl_nofill_ok", ok, 4'b0000);
    chk("dl_nofill_dout", dout[0], 16'h0000);
    cs = 4'd0; runCycles(4);

    // Reset in the middle of a request; slot 0 is searched first afterwards.
    addr[1] = 20'h00999; cs = 4'b0010;
    waitReq("rs_req");
    rst = 1'b1; applyStimulus();
    chk("rs_req_low", sdram_req, 1'b0);
    rst = 1'b0;
    addr[0] = 20'h00AAA; addr[2] = 20'h00BBB; addr[3] = 20'h00CCC; cs = 4'b1111;
    waitReq("rs_req2");
    chk("rs_first", sdram_addr, 22'h00_0AAA);

    // Random traffic with random handshakes, downloads and resets.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 7) == 0) cs[$urandom_range(0, 3)] ^= 1'b1;
      if ($urandom_range(0, 5) == 0) begin
        case ($urandom_range(0, 3))
          0: addr[$urandom_range(0, 3)] = 20'h00000;
          1: addr[$urandom_range(0, 3)] = 20'h00001;
          2: addr[$urandom_range(0, 3)] = 20'hFFFFF;
          default: addr[$urandom_range(0, 3)] = 20'h12345;
        endcase
      end
      sdram_ack   = ($urandom_range(0, 2) == 0);
      data_rdy    = ($urandom_range(0, 2) == 0);
      data_read   = $urandom;
      downloading = ($urandom_range(0, 39) == 0);
      rst         = ($urandom_range(0, 299) == 0);
      applyStimulus();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/jtdd2_romarb.md
JTDD2_ROMARB -- requirements
Module: jtdd2_romarb

Interface
REQ-001 Parameter SLOT0_OFFSET, default 22'h0, added to slot 0 address to form the SDRAM word address.
REQ-002 Parameter SLOT1_OFFSET, default 22'h0, same role for slot 1.
REQ-003 Parameter SLOT2_OFFSET, default 22'h0, same role for slot 2.
REQ-004 Parameter SLOT3_OFFSET, default 22'h0, same role for slot 3.
REQ-005 clk  input  1  system clock (48 MHz); the block uses one clock.
REQ-006 rst  input  1  reset; synchronous, active-high.
REQ-007 downloading  input  1  ROM download in progress; suspends arbitration.
REQ-008 slotN_cs  input  1  (N=0..3) slot N requests data.
REQ-009 slotN_addr  input  20  (N=0..3) slot N word address.
REQ-010 slotN_dout  output  16  (N=0..3) cached data for slot N.
REQ-011 slotN_ok  output  1  (N=0..3) slotN_dout is valid for the current slotN_addr.
REQ-012 sdram_req  output  1  read request to the SDRAM controller.
REQ-013 sdram_addr  output  22  SDRAM word address of the request.
REQ-014 sdram_ack  input  1  controller has accepted the request.
REQ-015 data_rdy  input  1  data_read is valid this cycle.
REQ-016 data_read  input  32  SDRAM read data; only bits 15:0 are used.
REQ-017 refresh_en  output  1  controller may refresh now.

Function
REQ-018 Each slot SHALL hold one cache entry: valid bit, 20-bit tag and 16-bit data.
REQ-019 slotN_ok SHALL be combinational: slotN_cs AND validN AND (tagN == slotN_addr).
REQ-020 slotN_dout SHALL always drive dataN, whatever the state of ok or cs.
REQ-021 A slot is pending when slotN_cs is 1 and slotN_ok is 0.
REQ-022 The FSM SHALL have three states: IDLE, REQ and WAIT.
REQ-023 IDLE, at least one slot pending and downloading=0: grant the slot at or after (last_grant+1) mod 4 in round-robin order; latch gnt_slot and gnt_addr=slot_addr; register sdram_addr=(SLOTn_OFFSET + {2'b0,addr}) mod 2^22; update last_grant; go to REQ.
REQ-024 REQ: sdram_req SHALL be 1; sdram_addr SHALL hold its value; on sdram_ack, go to WAIT with sdram_req=0 from the next cycle.
REQ-025 WAIT: on data_rdy, set data[gnt_slot]=data_read[15:0], tag[gnt_slot]=gnt_addr, valid[gnt_slot]=1; go to IDLE.
REQ-026 A change to slot_addr after the grant SHALL NOT abort the access: the fill uses the latched gnt_addr, ok stays 0 because of the tag mismatch, and the slot becomes pending again.
REQ-027 Dropping slot_cs mid-access SHALL NOT abort the access; the fill still completes.
REQ-028 Minimum latency: pending seen in IDLE at edge k; sdram_req=1 during cycle k+1; with ack at k+1 and data_rdy at k+2, ok=1 during cycle k+3.
REQ-029 sdram_ack seen in IDLE or WAIT, and data_rdy seen in IDLE or REQ, SHALL be ignored.
REQ-030 refresh_en SHALL be 1 only in IDLE with no pending slot and downloading=0.
REQ-031 While downloading=1, each cycle SHALL force: state IDLE, sdram_req=0, all valid bits 0, refresh_en=0. Tags and data keep their values.
REQ-032 If downloading rises during REQ or WAIT, the access SHALL be abandoned and no cache fill made.
REQ-033 Arbitration SHALL be work-conserving: with all four slots pending continuously, the grant order is 0,1,2,3,0,...

Reset
REQ-034 On rst=1 at a clock edge: state=IDLE, sdram_req=0, sdram_addr=0, all valid=0, all tags=0, all data=0, last_grant=3 (slot 0 is searched first).
REQ-035 On rst=1, all slotN_ok=0 and refresh_en=0 from the next cycle onward.
REQ-036 rst SHALL take precedence over downloading and over any handshake input.

Verification
REQ-037 SLOT1_OFFSET=22'h6_0000; slot1_cs=1, addr=20'h00010; ack 1 cycle after req; data_rdy 2 cycles after ack with data 32'hABCD_1234. Required: sdram_addr=22'h6_0010, slot1_dout=16'h1234, slot1_ok=1 one cycle after data_rdy.
REQ-038 All four cs high, distinct addresses, immediate ack/data. Required: grants in order 0,1,2,3 and all ok=1; a later miss on slot 2 is then granted before a miss on slot 0 if last_grant=1.
REQ-039 Slot 0 addr changes 5->6 while in WAIT. Required: fill tag=5, ok stays 0, and a second request for 6 follows.
REQ-040 downloading pulsed during WAIT, then data_rdy arrives. Required: no fill, all ok=0, sdram_req=0, refresh_en=0 while downloading.
REQ-041 rst asserted during REQ. Required: sdram_req=0 next cycle; after release, slot 0 is granted first.
REQ-042 Idle with no cs. Required: refresh_en=1, sdram_req=0; stray ack/data_rdy cause no state change.
